mvm_ctrl: RTL and testbench

Upstream sequencer for the matrix-vector engine: on a start pulse it walks the vector and matrix memories row by row and issues one read per cycle. It produces the valid/first/last control stream that feeds the accumulator. That stream is delayed to arrive at the accumulator in the same cycle as the dot-product data generated by the issued reads. The block owns no datapath arithmetic beyond address and loop counters.

---
 rtl/mvm_ctrl.sv | 146 ++++++++++++++
 tb/tb_mvm_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mvm_ctrl.sv
// Read sequencer for the matrix-vector engine: walks vector/matrix memories row by row
// and emits a valid/first/last stream aligned with the dot-product data at the accumulator.
module mvm_ctrl #(
  parameter int unsigned VEC_ADDRW = 8,
  parameter int unsigned MAT_ADDRW = 9,
  parameter int unsigned PIPE_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [VEC_ADDRW-1:0] vec_start_addr,
  input  logic [VEC_ADDRW:0]   vec_num_words,
  input  logic [MAT_ADDRW-1:0] mat_start_addr,
  input  logic [MAT_ADDRW:0]   mat_num_rows,
  output logic [VEC_ADDRW-1:0] vec_raddr,
  output logic [MAT_ADDRW-1:0] mat_raddr,
  output logic                 accum_ivalid,
  output logic                 accum_first,
  output logic                 accum_last,
  output logic                 busy
);

  localparam int unsigned VW1 = VEC_ADDRW + 1;
  localparam int unsigned MW1 = MAT_ADDRW + 1;
  localparam int unsigned CW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state;
  logic [VEC_ADDRW-1:0] vs_q;
  logic [VEC_ADDRW:0]   n_q;
  logic [MAT_ADDRW:0]   m_q;
  logic [VEC_ADDRW:0]   w_q;
  logic [MAT_ADDRW:0]   r_q;
  logic [CW-1:0]        drain_q;
  logic                 iss_v, iss_f, iss_l;
  logic [PIPE_LAT-1:0]  v_sr, f_sr, l_sr;

  logic [VEC_ADDRW:0]   n_last_c, w_inc_c;
  logic [MAT_ADDRW:0]   r_inc_c;
  logic                 w_last_c, r_last_c;

  assign n_last_c = n_q - VW1'(1);
  assign w_inc_c  = w_q + VW1'(1);
  assign r_inc_c  = r_q + MW1'(1);
  assign w_last_c = (w_q == n_last_c);
  assign r_last_c = (r_inc_c == m_q);

  // Control FSM with address/loop counters; issue flags describe the read on the address ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vs_q      <= '0;
      n_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      r_q       <= '0;
      drain_q   <= '0;
      iss_v     <= 1'b0;
      iss_f     <= 1'b0;
      iss_l     <= 1'b0;
      vec_raddr <= '0;
      mat_raddr <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vs_q <= vec_start_addr;
            n_q  <= vec_num_words;
            m_q  <= mat_num_rows;
            w_q  <= '0;
            r_q  <= '0;
            busy <= 1'b1;
            if (vec_num_words == '0 || mat_num_rows == '0) begin
              state   <= DRAIN;
              drain_q <= '0;
            end else begin
              state     <= ISSUE;
              vec_raddr <= vec_start_addr;
              mat_raddr <= mat_start_addr;
              iss_v     <= 1'b1;
              iss_f     <= 1'b1;
              iss_l     <= (vec_num_words == VW1'(1));
            end
          end
        end
        ISSUE: begin
          if (w_last_c && r_last_c) begin
            state   <= DRAIN;
            drain_q <= CW'(PIPE_LAT - 1);
            iss_v   <= 1'b0;
            iss_f   <= 1'b0;
            iss_l   <= 1'b0;
          end else begin
            mat_raddr <= mat_raddr + MAT_ADDRW'(1);
            if (w_last_c) begin
              w_q       <= '0;
              r_q       <= r_inc_c;
              vec_raddr <= vs_q;
              iss_f     <= 1'b1;
              iss_l     <= (n_q == VW1'(1));
            end else begin
              w_q       <= w_inc_c;
              vec_raddr <= vec_raddr + VEC_ADDRW'(1);
              iss_f     <= 1'b0;
              iss_l     <= (w_inc_c == n_last_c);
            end
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            drain_q <= drain_q - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line matching the memory + dot-product latency; flags gated by valid on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_sr <= '0;
      f_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr[0] <= iss_v;
      f_sr[0] <= iss_f & iss_v;
      l_sr[0] <= iss_l & iss_v;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        v_sr[i] <= v_sr[i-1];
        f_sr[i] <= f_sr[i-1];
        l_sr[i] <= l_sr[i-1];
      end
    end
  end

  assign accum_ivalid = v_sr[PIPE_LAT-1];
  assign accum_first  = f_sr[PIPE_LAT-1];
  assign accum_last   = l_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_mvm_ctrl.sv
// Scoreboard bench for mvm_ctrl: expected issues/accumulator flags/busy cycles are queued
// when a job is started and compared cycle by cycle at the falling edge.
module tb_mvm_ctrl;
  localparam int VW = 8;
  localparam int MW = 9;
  localparam int PL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VW-1:0] vec_start_addr;
  logic [VW:0]   vec_num_words;
  logic [MW-1:0] mat_start_addr;
  logic [MW:0]   mat_num_rows;
  logic [VW-1:0] vec_raddr;
  logic [MW-1:0] mat_raddr;
  logic          accum_ivalid, accum_first, accum_last, busy;

  mvm_ctrl #(.VEC_ADDRW(VW), .MAT_ADDRW(MW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_start_addr(vec_start_addr), .vec_num_words(vec_num_words),
    .mat_start_addr(mat_start_addr), .mat_num_rows(mat_num_rows),
    .vec_raddr(vec_raddr), .mat_raddr(mat_raddr),
    .accum_ivalid(accum_ivalid), .accum_first(accum_first),
    .accum_last(accum_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int c; logic [VW-1:0] va; logic [MW-1:0] ma; } addr_t;
  typedef struct { int c; logic f; logic l; } acc_t;

  addr_t aq[$];
  acc_t  cq[$];
  bit    busy_map[int];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Queue the expected behaviour of a job whose start is sampled at the end of cycle t.
  function automatic int push_job(int t, int vs, int n, int ms, int m);
    int idx = 0;
    if (n == 0 || m == 0) begin
      busy_map[t+1] = 1'b1;
      return t + 1;
    end
    for (int r = 0; r < m; r++)
      for (int w = 0; w < n; w++) begin
        aq.push_back('{t + 1 + idx, VW'(vs + w), MW'(ms + idx)});
        cq.push_back('{t + 1 + idx + PL, (w == 0), (w == n - 1)});
        idx++;
      end
    for (int c = t + 1; c <= t + n * m + PL; c++) busy_map[c] = 1'b1;
    return t + n * m + PL;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'(busy_map.exists(cyc)));
      while (cq.size() > 0 && cq[0].c < cyc) begin
        check("acc_missed", 32'(cyc), 32'(cq[0].c));
        void'(cq.pop_front());
      end
      if (cq.size() > 0 && cq[0].c == cyc) begin
        check("accum_ivalid", 32'(accum_ivalid), 32'd1);
        check("accum_first", 32'(accum_first), 32'(cq[0].f));
        check("accum_last", 32'(accum_last), 32'(cq[0].l));
        void'(cq.pop_front());
      end else begin
        check("accum_ivalid_idle", 32'(accum_ivalid), 32'd0);
        check("accum_first_idle", 32'(accum_first), 32'd0);
        check("accum_last_idle", 32'(accum_last), 32'd0);
      end
      if (aq.size() > 0 && aq[0].c == cyc) begin
        check("vec_raddr", 32'(vec_raddr), 32'(aq[0].va));
        check("mat_raddr", 32'(mat_raddr), 32'(aq[0].ma));
        void'(aq.pop_front());
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int vs, input int n, input int ms, input int m);
    vec_start_addr = VW'(vs);
    vec_num_words  = (VW+1)'(n);
    mat_start_addr = MW'(ms);
    mat_num_rows   = (MW+1)'(m);
  endtask

  task automatic run_job(input int vs, input int n, input int ms, input int m);
    int e;
    @(posedge clk); #1;
    drive_cfg(vs, n, ms, m);
    start = 1'b1;
    e = push_job(cyc, vs, n, ms, m);
    @(posedge clk); #1;
    start = 1'b0;
    drive_cfg($urandom_range(255), $urandom_range(9), $urandom_range(511), $urandom_range(9));
    wait_until(e + 2);
  endtask

  initial begin
    int t, e, r0;
    rst = 1'b1;
    start = 1'b0;
    drive_cfg(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_vec_raddr", 32'(vec_raddr), 32'd0);
    check("reset_mat_raddr", 32'(mat_raddr), 32'd0);
    repeat (2) @(posedge clk);

    run_job(4, 3, 10, 2);     // basic
    run_job(7, 1, 3, 1);      // single element
    run_job(9, 0, 20, 5);     // zero words
    run_job(9, 5, 20, 0);     // zero rows

    // Start pulses with other configs during ISSUE and DRAIN are ignored.
    @(posedge clk); #1;
    t = cyc;
    drive_cfg(20, 3, 100, 3);
    start = 1'b1;
    e = push_job(t, 20, 3, 100, 3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_until(t + 3);
    drive_cfg(50, 2, 7, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_until(t + 11);
    drive_cfg(60, 1, 8, 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_until(e + 2);

    // Held start: address wrap on both memories, second job accepted in the first IDLE cycle.
    @(posedge clk); #1;
    t = cyc;
    drive_cfg(254, 4, 510, 2);
    start = 1'b1;
    e = push_job(t, 254, 4, 510, 2);
    @(posedge clk); #1;
    drive_cfg(30, 2, 40, 2);
    e = push_job(e + 1, 30, 2, 40, 2);
    wait_until(t + 13);
    start = 1'b0;
    wait_until(e + 2);

    // Reset mid-job: expectations past the first reset edge are discarded.
    @(posedge clk); #1;
    t = cyc;
    drive_cfg(0, 4, 0, 3);
    start = 1'b1;
    e = push_job(t, 0, 4, 0, 3);
    @(posedge clk); #1;
    start = 1'b0;
    wait_until(t + 5);
    rst = 1'b1;
    r0 = cyc;
    while (aq.size() > 0 && aq[$].c > r0) void'(aq.pop_back());
    while (cq.size() > 0 && cq[$].c > r0) void'(cq.pop_back());
    for (int c = r0 + 1; c <= e; c++) if (busy_map.exists(c)) busy_map.delete(c);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_reset_vec_raddr", 32'(vec_raddr), 32'd0);
    check("post_reset_mat_raddr", 32'(mat_raddr), 32'd0);
    wait_until(cyc + 12);

    run_job(100, 2, 200, 3);  // clean job after reset

    check("addr_queue_empty", 32'(aq.size()), 32'd0);
    check("acc_queue_empty", 32'(cq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1);
  end
endmodule
